// File: rtl/sdio_switch_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdio_switch_sequencer_if : APB slave bus bundle for the sequencer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface sdio_switch_sequencer_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface
`default_nettype wire

// File: rtl/sdio_switch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdio_switch_sequencer : APB-controlled SD/eMMC mux switch sequence  |
// | (drain host, power off, flip select, power on, settle). Rev 1.0    |
// +--------------------------------------------------------------------+
module sdio_switch_sequencer #(
   parameter logic        RESET_SEL   = 1'b0,
   parameter logic [15:0] SETTLE_RST  = 16'd50000,
   parameter logic [15:0] TIMEOUT_RST = 16'hFFFF
) (
   input  wire                           pclk,
   input  wire                           presetn,
   sdio_switch_sequencer_if.slave        apb,
   input  wire                           host_busy,
   output logic                          SDIO_control,
   output logic                          card_pwr_en,
   output logic                          seq_irq
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DRAIN   = 3'd1,
      S_PWR_OFF = 3'd2,
      S_SWITCH  = 3'd3,
      S_PWR_ON  = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        sel_q, sel_d;
   logic        pwr_q, pwr_d;
   logic        tgt_q, tgt_d;
   logic        same_q, same_d;
   logic        target_q, target_d;
   logic        irq_en_q, irq_en_d;
   logic        done_q, done_d;
   logic        terr_q, terr_d;
   logic [15:0] settle_q, settle_d;
   logic [15:0] timeout_q, timeout_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;
   logic        irq_q, irq_d;

   logic        w_setup;
   logic        w_wr;
   logic [1:0]  w_addr;
   logic        w_go_ok;
   logic        w_set_done;
   logic        w_set_terr;
   logic [15:0] w_settle_ld;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_setup     = apb.psel & ~apb.penable;
   assign w_wr        = apb.psel & apb.penable & pready_q & apb.pwrite;
   assign w_addr      = apb.paddr[3:2];
   // A GO flagged with pslverr in its setup phase must not start anything.
   assign w_go_ok     = w_wr & (w_addr == 2'd0) & apb.pwdata[1] & ~pslverr_q & (state_q == S_IDLE);
   assign w_settle_ld = (settle_q == 16'd0) ? 16'd0 : settle_q - 16'd1;
   assign w_unused    = ^{apb.paddr[31:4], apb.paddr[1:0], apb.pwdata[31:16]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      pwr_d      = pwr_q;
      tgt_d      = tgt_q;
      same_d     = 1'b0;
      w_set_done = same_q;
      w_set_terr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_go_ok) begin
               tgt_d = apb.pwdata[0];
               if (apb.pwdata[0] == sel_q) begin
                  same_d = 1'b1;
               end else begin
                  state_d = S_DRAIN;
                  cnt_d   = timeout_q;
               end
            end
         end
         S_DRAIN: begin
            // A counter loaded with 0 never reaches 1, so it waits forever.
            if (!host_busy) begin
               state_d = S_PWR_OFF;
               pwr_d   = 1'b0;
               cnt_d   = w_settle_ld;
            end else if (cnt_q == 16'd1) begin
               state_d    = S_IDLE;
               w_set_terr = 1'b1;
            end else if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_PWR_OFF: begin
            if (cnt_q == 16'd0) begin
               state_d = S_SWITCH;
               sel_d   = tgt_q;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_SWITCH: begin
            state_d = S_PWR_ON;
            pwr_d   = 1'b1;
            cnt_d   = w_settle_ld;
         end
         S_PWR_ON: begin
            if (cnt_q == 16'd0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            w_set_done = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (w_addr)
         2'd0:    w_rdata = {29'd0, irq_en_q, 1'b0, target_q};
         2'd1:    w_rdata = {25'd0, state_q, done_q, terr_q, (state_q != S_IDLE), sel_q};
         2'd2:    w_rdata = {16'd0, settle_q};
         default: w_rdata = {16'd0, timeout_q};
      endcase
   end

   always_comb begin
      target_d  = target_q;
      irq_en_d  = irq_en_q;
      settle_d  = settle_q;
      timeout_d = timeout_q;
      if (w_wr) begin
         case (w_addr)
            2'd0: begin
               target_d = apb.pwdata[0];
               irq_en_d = apb.pwdata[2];
            end
            2'd2:    settle_d  = apb.pwdata[15:0];
            2'd3:    timeout_d = apb.pwdata[15:0];
            default: ;
         endcase
      end
      // Hardware set beats a simultaneous write-1-to-clear.
      done_d    = (done_q & ~(w_wr & (w_addr == 2'd1) & apb.pwdata[3])) | w_set_done;
      terr_d    = (terr_q & ~(w_wr & (w_addr == 2'd1) & apb.pwdata[2])) | w_set_terr;
      irq_d     = irq_en_d & (done_d | terr_d);
      pready_d  = w_setup;
      prdata_d  = (w_setup & ~apb.pwrite) ? w_rdata : 32'd0;
      pslverr_d = w_setup & apb.pwrite & (w_addr == 2'd0) & apb.pwdata[1] & (state_q != S_IDLE);
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         sel_q     <= RESET_SEL;
         pwr_q     <= 1'b1;
         tgt_q     <= RESET_SEL;
         same_q    <= 1'b0;
         target_q  <= RESET_SEL;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         terr_q    <= 1'b0;
         settle_q  <= SETTLE_RST;
         timeout_q <= TIMEOUT_RST;
         prdata_q  <= 32'd0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         pwr_q     <= pwr_d;
         tgt_q     <= tgt_d;
         same_q    <= same_d;
         target_q  <= target_d;
         irq_en_q  <= irq_en_d;
         done_q    <= done_d;
         terr_q    <= terr_d;
         settle_q  <= settle_d;
         timeout_q <= timeout_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         irq_q     <= irq_d;
      end
   end

   assign apb.prdata  = prdata_q;
   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign SDIO_control = sel_q;
   assign card_pwr_en  = pwr_q;
   assign seq_irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sdio_switch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sdio_switch_sequencer : randomized sequences checked against a   |
// | cycle-timeline model of the switch sequence. Rev 1.0               |
// +--------------------------------------------------------------------+
module tb_sdio_switch_sequencer;

   logic pclk      = 1'b0;
   logic presetn   = 1'b0;
   logic host_busy = 1'b0;
   logic sdio_ctl;
   logic pwr;
   logic irq;

   sdio_switch_sequencer_if bus ();

   sdio_switch_sequencer #(
      .RESET_SEL   (1'b0),
      .SETTLE_RST  (16'd50000),
      .TIMEOUT_RST (16'hFFFF)
   ) dut (
      .pclk         (pclk),
      .presetn      (presetn),
      .apb          (bus),
      .host_busy    (host_busy),
      .SDIO_control (sdio_ctl),
      .card_pwr_en  (pwr),
      .seq_irq      (irq)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int k        = 0;
   int rd_k     = 0;
   bit mon      = 1'b0;

   // Timeline model: edge k counted from the GO commit edge (k = 0).
   int m_n, m_s, m_b, m_end;
   bit m_same, m_tout, m_tgt, m_old, m_irqen;
   bit cur_sel = 1'b0;

   function automatic bit exp_pwr(int kk);
      if (m_same || m_tout) return 1'b1;
      return !(kk >= 1 + m_s && kk <= 1 + m_s + m_n);
   endfunction

   function automatic bit exp_sel(int kk);
      if (m_same || m_tout) return m_old;
      return (kk >= 1 + m_s + m_n) ? m_tgt : m_old;
   endfunction

   function automatic bit exp_irq(int kk);
      return m_irqen && (kk >= m_end);
   endfunction

   function automatic int exp_state(int kk);
      if (m_same || kk < 0) return 0;
      if (m_tout) return (kk < m_end) ? 1 : 0;
      if (kk < 1 + m_s) return 1;
      if (kk < 1 + m_s + m_n) return 2;
      if (kk == 1 + m_s + m_n) return 3;
      if (kk < 2 + m_s + 2 * m_n) return 4;
      if (kk == 2 + m_s + 2 * m_n) return 5;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
      k++;
      if (mon) begin
         if (k == m_b) host_busy = 1'b0;
         check($sformatf("card_pwr_en@E%0d", k), {31'd0, pwr}, {31'd0, exp_pwr(k)});
         check($sformatf("SDIO_control@E%0d", k), {31'd0, sdio_ctl}, {31'd0, exp_sel(k)});
         check($sformatf("seq_irq@E%0d", k), {31'd0, irq}, {31'd0, exp_irq(k)});
      end
   endtask

   task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
      tick();
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = {28'd0, addr}; bus.pwdata = data;
      tick();
      bus.penable = 1'b1;
      check("pready_wr", {31'd0, bus.pready}, 32'd1);
      err = bus.pslverr;
      tick();
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
      tick();
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = {28'd0, addr};
      tick();
      rd_k = k - 1;
      bus.penable = 1'b1;
      check("pready_rd", {31'd0, bus.pready}, 32'd1);
      data = bus.prdata;
      tick();
      bus.psel = 1'b0; bus.penable = 1'b0;
      check("prdata_idle", bus.prdata, 32'd0);
   endtask

   task automatic start_seq(input int settle, input int b, input int t, input bit irqen, input bit same);
      logic e;
      mon = 1'b0;
      apb_write(4'h8, settle, e);
      apb_write(4'hC, t, e);
      m_n     = (settle == 0) ? 1 : settle;
      m_s     = same ? 0 : b;
      m_b     = m_s;
      m_old   = cur_sel;
      m_tgt   = same ? cur_sel : ~cur_sel;
      m_same  = same;
      m_irqen = irqen;
      m_tout  = !same && (t != 0) && (m_s >= t);
      m_end   = same ? 1 : (m_tout ? t : 3 + m_s + 2 * m_n);
      host_busy = (m_s > 0);
      apb_write(4'h0, {29'd0, irqen, 1'b1, m_tgt}, e);
      check("go_pslverr", {31'd0, e}, 32'd0);
      k   = 0;
      mon = 1'b1;
   endtask

   task automatic finish_seq();
      logic [31:0] d;
      logic        e;
      while (k < m_end + 2) tick();
      mon = 1'b0;
      host_busy = 1'b0;
      apb_read(4'h4, d);
      check("status_end", d, {28'd0, !m_tout, m_tout, 1'b0, (m_tout ? m_old : m_tgt)});
      apb_write(4'h4, 32'hC, e);
      apb_read(4'h4, d);
      check("status_w1c", d, {31'd0, (m_tout ? m_old : m_tgt)});
      check("irq_cleared", {31'd0, irq}, 32'd0);
      if (!m_tout) cur_sel = m_tgt;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      logic [2:0]  st;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = 32'd0; bus.pwdata = 32'd0;

      repeat (3) tick();
      check("rst_pwr", {31'd0, pwr}, 32'd1);
      check("rst_sel", {31'd0, sdio_ctl}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_pready", {31'd0, bus.pready}, 32'd0);
      check("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
      check("rst_prdata", bus.prdata, 32'd0);
      presetn = 1'b1;
      apb_read(4'h4, d);
      check("rst_status", d, 32'd0);
      apb_read(4'h8, d);
      check("rst_settle", d, 32'd50000);
      apb_read(4'hC, d);
      check("rst_timeout", d, 32'h0000FFFF);

      // Directed: plain sequence, timeout, drain hold, same-target, settle 0.
      start_seq(4, 0, 0, 1'b1, 1'b0);  finish_seq();
      start_seq(4, 12, 10, 1'b1, 1'b0); finish_seq();
      start_seq(4, 3, 0, 1'b0, 1'b0);  finish_seq();
      start_seq(3, 0, 0, 1'b1, 1'b1);  finish_seq();
      start_seq(0, 0, 0, 1'b0, 1'b0);  finish_seq();

      // GO during a running sequence is refused and the sequence is unaffected.
      start_seq(6, 0, 0, 1'b1, 1'b0);
      apb_read(4'h4, d);
      st = 3'(exp_state(rd_k));
      check("status_mid", d, {25'd0, st, 2'b00, (st != 3'd0), exp_sel(rd_k)});
      apb_write(4'h0, {29'd0, 1'b1, 1'b1, m_old}, e);
      check("busy_go_pslverr", {31'd0, e}, 32'd1);
      finish_seq();

      for (int i = 0; i < 12; i++) begin
         start_seq($urandom_range(0, 6), $urandom_range(0, 5),
                   ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
         finish_seq();
      end

      // Reset in the middle of PWR_OFF.
      start_seq(8, 0, 0, 1'b0, 1'b0);
      while (k < 3) tick();
      mon = 1'b0;
      presetn = 1'b0;
      tick();
      check("midrst_pwr", {31'd0, pwr}, 32'd1);
      check("midrst_sel", {31'd0, sdio_ctl}, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      presetn = 1'b1;
      cur_sel = 1'b0;
      apb_read(4'h4, d);
      check("midrst_status", d, 32'd0);
      apb_read(4'h0, d);
      check("midrst_ctrl", d, 32'd0);
      apb_read(4'h8, d);
      check("midrst_settle", d, 32'd50000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
